// File: rtl/tcas_dsp_pkg.sv
// Shared constants and types for the TCAS DSP CORDIC datapath.
// Holds the CORDIC arctangent table, datapath widths, the gain
// compensation constant and the output saturation helper.
package tcas_dsp_pkg;

    localparam int CORDIC_W        = 26;
    localparam int PHASE_W         = 16;
    localparam int MAG_W           = 23;
    localparam int IQ_W            = 24;
    localparam int GAIN_COMP_NUM   = 19898;
    localparam int GAIN_COMP_SHIFT = 15;

    // round(atan(2^-k) * 65536 / (2*pi)) for k = 0..15
    localparam logic [PHASE_W-1:0] ATAN_TABLE [16] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297,
        16'd651,  16'd326,  16'd163,  16'd81,
        16'd41,   16'd20,   16'd10,   16'd5,
        16'd3,    16'd1,    16'd1,    16'd0
    };

    // Symmetric output limits: +/-(2^23-1), so the most negative code is never produced
    localparam logic signed [CORDIC_W-1:0] SAT_HI = 26'sd8388607;
    localparam logic signed [CORDIC_W-1:0] SAT_LO = -26'sd8388607;

    // Quadrant selected by the top two phase bits
    typedef enum logic [1:0] {
        QUAD_0   = 2'b00,
        QUAD_90  = 2'b01,
        QUAD_180 = 2'b10,
        QUAD_270 = 2'b11
    } quadrant_e;

    // Clamp a wide CORDIC result into the signed 24-bit output range
    function automatic logic signed [IQ_W-1:0] sat_iq(input logic signed [CORDIC_W-1:0] v);
        logic signed [CORDIC_W-1:0] c;
        if (v > SAT_HI) begin
            c = SAT_HI;
        end else if (v < SAT_LO) begin
            c = SAT_LO;
        end else begin
            c = v;
        end
        return c[IQ_W-1:0];
    endfunction

endpackage

// File: rtl/polar_to_iq_stage.sv
// One CORDIC micro-rotation (rotation mode). Rotates (x, y) towards the
// residual angle z by +/-atan(2^-NUM_STAGE); the valid bit rides alongside.
module polar_to_iq_stage
    import tcas_dsp_pkg::*;
#(
    parameter int NUM_STAGE = 0
) (
    input  logic                       clk,
    input  logic                       reset_b,
    input  logic                       valid_in,
    input  logic signed [CORDIC_W-1:0] x_in,
    input  logic signed [CORDIC_W-1:0] y_in,
    input  logic signed [PHASE_W-1:0]  z_in,
    output logic                       valid_out,
    output logic signed [CORDIC_W-1:0] x_out,
    output logic signed [CORDIC_W-1:0] y_out,
    output logic signed [PHASE_W-1:0]  z_out
);

    localparam logic signed [PHASE_W-1:0] ATAN_K = signed'(ATAN_TABLE[NUM_STAGE]);

    logic signed [CORDIC_W-1:0] x_shift;
    logic signed [CORDIC_W-1:0] y_shift;

    // Arithmetic shifts truncate toward minus infinity; no rounding is applied
    assign x_shift = x_in >>> NUM_STAGE;
    assign y_shift = y_in >>> NUM_STAGE;

    // Rotate in the direction that drives the residual angle toward zero
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            valid_out <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
        end else begin
            valid_out <= valid_in;
            if (z_in >= 0) begin
                x_out <= x_in - y_shift;
                y_out <= y_in + x_shift;
                z_out <= z_in - ATAN_K;
            end else begin
                x_out <= x_in + y_shift;
                y_out <= y_in - x_shift;
                z_out <= z_in + ATAN_K;
            end
        end
    end

endmodule

// File: rtl/polar_to_iq.sv
// Pipelined polar-to-I/Q CORDIC rotator, one sample per clock.
// Handshake: valid_in qualifies mag_in/phase_in in the cycle it is high;
// valid_out marks a new sig_i/sig_q exactly L cycles later. There is no
// ready/backpressure, the pipeline always advances.
// Optional feature macro: POLAR_TO_IQ_GAIN_COMP_EN adds a registered
// 1/K magnitude prescale ahead of the pre-rotation (one more cycle of latency).
module polar_to_iq
    import tcas_dsp_pkg::*;
#(
    parameter int NUM_STAGES = 12
) (
    input  logic                   clk,
    input  logic                   reset_b,
    input  logic                   valid_in,
    input  logic [MAG_W-1:0]       mag_in,
    input  logic [PHASE_W-1:0]     phase_in,
    output logic                   valid_out,
    output logic signed [IQ_W-1:0] sig_i,
    output logic signed [IQ_W-1:0] sig_q
);

    localparam int PROD_W = MAG_W + GAIN_COMP_SHIFT;

    logic               g_valid;
    logic [MAG_W-1:0]   g_mag;
    logic [PHASE_W-1:0] g_phase;

`ifdef POLAR_TO_IQ_GAIN_COMP_EN
    logic [PROD_W-1:0] gain_prod;

    assign gain_prod = PROD_W'(mag_in) * PROD_W'(GAIN_COMP_NUM);

    // Prescale magnitude by ~1/K so the CORDIC gain cancels out
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            g_valid <= 1'b0;
            g_mag   <= '0;
            g_phase <= '0;
        end else begin
            g_valid <= valid_in;
            g_mag   <= MAG_W'(gain_prod >> GAIN_COMP_SHIFT);
            g_phase <= phase_in;
        end
    end
`else
    assign g_valid = valid_in;
    assign g_mag   = mag_in;
    assign g_phase = phase_in;
`endif

    logic signed [CORDIC_W-1:0] mag_ext;
    assign mag_ext = signed'({{(CORDIC_W - MAG_W){1'b0}}, g_mag});

    logic                       pre_valid;
    logic signed [CORDIC_W-1:0] pre_x;
    logic signed [CORDIC_W-1:0] pre_y;
    logic signed [PHASE_W-1:0]  pre_z;

    // Quadrant pre-rotation folds the phase into [-90, +90] degrees
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            pre_valid <= 1'b0;
            pre_x     <= '0;
            pre_y     <= '0;
            pre_z     <= '0;
        end else begin
            pre_valid <= g_valid;
            case (quadrant_e'(g_phase[PHASE_W-1:PHASE_W-2]))
                QUAD_90: begin
                    pre_x <= '0;
                    pre_y <= mag_ext;
                    pre_z <= signed'(g_phase - 16'h4000);
                end
                QUAD_180: begin
                    pre_x <= '0;
                    pre_y <= -mag_ext;
                    pre_z <= signed'(g_phase + 16'h4000);
                end
                default: begin
                    pre_x <= mag_ext;
                    pre_y <= '0;
                    pre_z <= signed'(g_phase);
                end
            endcase
        end
    end

    logic                       st_valid [NUM_STAGES];
    logic signed [CORDIC_W-1:0] st_x     [NUM_STAGES];
    logic signed [CORDIC_W-1:0] st_y     [NUM_STAGES];
    logic signed [PHASE_W-1:0]  st_z     [NUM_STAGES];

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic                       v_i;
        logic signed [CORDIC_W-1:0] x_i;
        logic signed [CORDIC_W-1:0] y_i;
        logic signed [PHASE_W-1:0]  z_i;

        if (k == 0) begin : g_first
            assign v_i = pre_valid;
            assign x_i = pre_x;
            assign y_i = pre_y;
            assign z_i = pre_z;
        end else begin : g_next
            assign v_i = st_valid[k-1];
            assign x_i = st_x[k-1];
            assign y_i = st_y[k-1];
            assign z_i = st_z[k-1];
        end

        polar_to_iq_stage #(
            .NUM_STAGE(k)
        ) u_stage (
            .clk      (clk),
            .reset_b  (reset_b),
            .valid_in (v_i),
            .x_in     (x_i),
            .y_in     (y_i),
            .z_in     (z_i),
            .valid_out(st_valid[k]),
            .x_out    (st_x[k]),
            .y_out    (st_y[k]),
            .z_out    (st_z[k])
        );
    end

    // Output register: load saturated I/Q only for valid samples, hold otherwise
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            valid_out <= 1'b0;
            sig_i     <= '0;
            sig_q     <= '0;
        end else begin
            valid_out <= st_valid[NUM_STAGES-1];
            if (st_valid[NUM_STAGES-1]) begin
                sig_i <= sat_iq(st_x[NUM_STAGES-1]);
                sig_q <= sat_iq(st_y[NUM_STAGES-1]);
            end
        end
    end

endmodule

// File: tb/tb_polar_to_iq.sv
// Testbench for polar_to_iq. Expected I/Q come from a floating-point
// polar-to-rectangular model scaled by the CORDIC gain (or its compensated
// value when POLAR_TO_IQ_GAIN_COMP_EN is defined).
module tb_polar_to_iq;

    localparam int NUM_STAGES = 12;
`ifdef POLAR_TO_IQ_GAIN_COMP_EN
    localparam int LAT = NUM_STAGES + 3;
    localparam bit GAIN_COMP = 1'b1;
`else
    localparam int LAT = NUM_STAGES + 2;
    localparam bit GAIN_COMP = 1'b0;
`endif
    localparam real    PI     = 3.14159265358979323846;
    localparam longint IQ_MAX = 8388607;

    logic               clk;
    logic               reset_b;
    logic               valid_in;
    logic [22:0]        mag_in;
    logic [15:0]        phase_in;
    logic               valid_out;
    logic signed [23:0] sig_i;
    logic signed [23:0] sig_q;

    polar_to_iq #(
        .NUM_STAGES(NUM_STAGES)
    ) dut (
        .clk      (clk),
        .reset_b  (reset_b),
        .valid_in (valid_in),
        .mag_in   (mag_in),
        .phase_in (phase_in),
        .valid_out(valid_out),
        .sig_i    (sig_i),
        .sig_q    (sig_q)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- scoreboard state ----------------
    int     n_vec = 0;
    int     n_err = 0;
    longint exp_i_q[$];
    longint exp_q_q[$];
    longint tol_i_q[$];
    longint tol_q_q[$];
    int     due_q[$];
    logic signed [23:0] last_i;
    logic signed [23:0] last_q;
    bit     mon_en = 1'b0;
    real    gain;

    task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
        n_vec++;
        if ((obs - exp > tol) || (exp - obs > tol)) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", tag, obs, exp, tol, cyc);
        end
    endtask

    function automatic real cordic_gain();
        real k = 1.0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            k = k * $sqrt(1.0 + 1.0 / (4.0 ** s));
        end
        if (GAIN_COMP) begin
            k = k * 19898.0 / 32768.0;
        end
        return k;
    endfunction

    task automatic push_expected(input int mag, input int phase, input longint tol_fix);
        real    amp, ang, ri, rq;
        longint ei, eq, ti, tq;
        amp = real'(mag) * gain;
        ang = 2.0 * PI * real'(phase) / 65536.0;
        ri  = amp * $cos(ang);
        rq  = amp * $sin(ang);
        ti  = longint'(amp / 512.0) + 32;
        tq  = ti;
        if (tol_fix >= 0) begin
            ti = tol_fix;
            tq = tol_fix;
        end
        if (ri > real'(IQ_MAX)) begin
            ei = IQ_MAX;  ti = 0;
        end else if (ri < -real'(IQ_MAX)) begin
            ei = -IQ_MAX; ti = 0;
        end else begin
            ei = longint'(ri);
        end
        if (rq > real'(IQ_MAX)) begin
            eq = IQ_MAX;  tq = 0;
        end else if (rq < -real'(IQ_MAX)) begin
            eq = -IQ_MAX; tq = 0;
        end else begin
            eq = longint'(rq);
        end
        exp_i_q.push_back(ei);
        exp_q_q.push_back(eq);
        tol_i_q.push_back(ti);
        tol_q_q.push_back(tq);
        due_q.push_back(cyc + LAT);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit v, input int mag, input int phase, input longint tol_fix = -1);
        @(negedge clk);
        valid_in = v;
        mag_in   = 23'(mag);
        phase_in = 16'(phase);
        if (v) begin
            push_expected(mag, phase, tol_fix);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < LAT + 8 && due_q.size() > 0; i++) begin
            drive(1'b0, 0, 0);
        end
        drive(1'b0, 0, 0);
    endtask

    task automatic clear_scoreboard();
        exp_i_q.delete();
        exp_q_q.delete();
        tol_i_q.delete();
        tol_q_q.delete();
        due_q.delete();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en && reset_b) begin
            if (valid_out) begin
                if (due_q.size() == 0) begin
                    check("spurious_valid", 1, 0, 0);
                end else begin
                    check("latency", cyc, due_q.pop_front(), 0);
                    check("sig_i", sig_i, exp_i_q.pop_front(), tol_i_q.pop_front());
                    check("sig_q", sig_q, exp_q_q.pop_front(), tol_q_q.pop_front());
                end
                last_i = sig_i;
                last_q = sig_q;
            end else begin
                check("hold_i", sig_i, last_i, 0);
                check("hold_q", sig_q, last_q, 0);
                if (due_q.size() > 0 && due_q[0] <= cyc) begin
                    check("missed_valid", 0, 1, 0);
                    void'(due_q.pop_front());
                    void'(exp_i_q.pop_front());
                    void'(exp_q_q.pop_front());
                    void'(tol_i_q.pop_front());
                    void'(tol_q_q.pop_front());
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int quad_ph [4];
        bit pat [5];
        quad_ph = '{0, 16'h4000, 16'h8000, 16'hC000};
        pat     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        gain     = cordic_gain();
        reset_b  = 1'b0;
        valid_in = 1'b0;
        mag_in   = '0;
        phase_in = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_valid", valid_out, 0, 0);
        check("rst_i", sig_i, 0, 0);
        check("rst_q", sig_q, 0, 0);
        reset_b = 1'b1;
        last_i  = '0;
        last_q  = '0;
        mon_en  = 1'b1;

        // idle after reset: outputs must stay zero with no valid_out
        repeat (20) drive(1'b0, 0, 0);

        // quadrant points, isolated samples
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1000000, quad_ph[i]);
            repeat (3) drive(1'b0, 0, 0);
        end
        drain();

        // 45 degrees
        if (GAIN_COMP) drive(1'b1, 1000000, 16'h2000);
        else           drive(1'b1, 1000000, 16'h2000, 2000);
        drain();

        // full phase sweep, back-to-back
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 4000000, i * 257);
        end
        drain();

        // full-scale magnitude on the positive and negative I axis
        drive(1'b1, 8388607, 0);
        drive(1'b1, 8388607, 16'h8000);
        drain();

        // gap pattern 1,0,0,1,1 with random samples
        for (int i = 0; i < 5; i++) begin
            drive(pat[i], int'($urandom_range(100000, 4000000)), int'($urandom_range(0, 65535)));
        end
        drain();

        // random valid bursts
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 5000000)), int'($urandom_range(0, 65535)));
        end
        drain();

        // reset with five samples in flight
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2000000, i * 1000);
        end
        @(negedge clk);
        valid_in = 1'b0;
        reset_b  = 1'b0;
        clear_scoreboard();
        #1;
        check("mid_rst_valid", valid_out, 0, 0);
        check("mid_rst_i", sig_i, 0, 0);
        check("mid_rst_q", sig_q, 0, 0);
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        last_i  = '0;
        last_q  = '0;
        repeat (LAT + 6) drive(1'b0, 0, 0);

        // pipeline still works after the reset
        drive(1'b1, 3000000, 16'h6000);
        drain();

        check("queue_empty", due_q.size(), 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
